// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU
// functions, datapath select codes and the bundled control-word type.
package mc_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NEG  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LDR  = 4'b0101;
  localparam logic [3:0] OP_STR  = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_NOP  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_NEG = 3'b100;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       halted;
    logic [3:0] state_dbg;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_NEG);
  endfunction

  function automatic logic [2:0] rtype_alu_op(input logic [3:0] op);
    logic [2:0] f;
    case (op)
      OP_SUB:  f = ALU_SUB;
      OP_AND:  f = ALU_AND;
      OP_NEG:  f = ALU_NEG;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decoder for the multicycle FSM. mem_ok is the
// memory handshake (driven by mem_ready under MC_MEM_WAIT_EN, else tied high).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ok,
  output ctrl_t      ctrl
);

  state_e dec_state;

  always_comb begin
    // While in reset the datapath sees the FETCH selects with every enable low.
    dec_state      = rst ? S_FETCH : state;
    ctrl           = '0;
    ctrl.state_dbg = dec_state;
    case (dec_state)
      S_FETCH: begin
        ctrl.mem_read  = !rst;
        ctrl.ir_write  = !rst && mem_ok;
        ctrl.pc_write  = !rst && mem_ok;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_OFF;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = rtype_alu_op(opcode);
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_dst    = is_rtype(opcode);
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BLT) && neg);
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register, next-state logic and the
// control-word decoder. Define MC_MEM_WAIT_EN to add the mem_ready handshake.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       neg,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic [3:0] state_dbg
);

  state_e state_q;
  state_e state_d;
  logic   mem_ok;
  ctrl_t  ctrl;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Opcode comes straight from the IR, which is stable from DECODE onward.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_NEG: state_d = S_EXEC_R;
            OP_ADDI:                        state_d = S_EXEC_I;
            OP_LDR, OP_STR:                 state_d = S_MEM_ADDR;
            OP_BEQ, OP_BLT:                 state_d = S_BRANCH;
            OP_JMP:                         state_d = S_JUMP;
            OP_HALT:                        state_d = S_HALT;
            default:                        state_d = S_FETCH;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
        S_MEM_ADDR: state_d = (opcode == OP_LDR) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state_d = mem_ok ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR:   state_d = mem_ok ? S_FETCH : S_MEM_WR;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_HALT:     state_d = S_HALT;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state  (state_q),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .neg    (neg),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;
  assign halted     = ctrl.halted;
  assign state_dbg  = ctrl.state_dbg;

endmodule
